// File: rtl/touch_coord_mapper.sv
// -----------------------------------------------------------------------------
// touch_coord_mapper
//
// Converts raw averaged touchpad samples (x, y, z) into screen pixel
// coordinates for an 800x480 display and debounces the touch state into
// PRESS / MOVE / RELEASE events.
//
// Each accepted sample walks IDLE -> CLAMP -> MUL (16 cycles) -> FINISH.
// The x/y scaling is a fixed-point multiply (adj * K) >> 16, done with a
// 1-bit-per-cycle shift-add multiplier on both axes at once.
//
// Ports:
//   cclk        system clock, all logic on posedge
//   rst         synchronous active-high reset
//   in_valid    single-cycle strobe for a new x/y/z sample
//   x, y, z     raw 12-bit coordinates and pressure
//   busy        high whenever the FSM is not in IDLE
//   out_valid   single-cycle event strobe
//   event_type  01 = PRESS, 10 = MOVE, 11 = RELEASE (held until next event)
//   pix_x       screen x, 0..799
//   pix_y       screen y, 0..479
//   touch_down  debounced touch state
//   overrun     sticky: a sample arrived while busy and was dropped
//
// Optional feature: define TOUCH_FILTER_EN to average each MOVE position
// with the previously reported one.
// -----------------------------------------------------------------------------
module touch_coord_mapper #(
    parameter logic [11:0] X_MIN       = 12'h090,
    parameter logic [11:0] X_SPAN      = 12'h745,
    parameter logic [11:0] Y_MIN       = 12'h060,
    parameter logic [11:0] Y_SPAN      = 12'h6F0,
    parameter logic [15:0] K_X         = 16'd28172,
    parameter logic [15:0] K_Y         = 16'd17712,
    parameter logic [11:0] Z_THRESH    = 12'h080,
    parameter int          PRESS_CNT   = 3,
    parameter int          RELEASE_CNT = 2
) (
    input  logic        cclk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  logic [11:0] z,
    output logic        busy,
    output logic        out_valid,
    output logic [1:0]  event_type,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        touch_down,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, CLAMP, MUL, FINISH} state_t;

    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_MOVE    = 2'b10;
    localparam logic [1:0] EV_RELEASE = 2'b11;
    localparam logic [2:0] PRESS_CNT3   = 3'(PRESS_CNT);
    localparam logic [2:0] RELEASE_CNT3 = 3'(RELEASE_CNT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [11:0] x_q, y_q, z_q;
    logic [26:0] mcand_x_q, mcand_y_q, acc_x_q, acc_y_q;
    logic [15:0] mplier_x_q, mplier_y_q;
    logic [2:0]  press_cnt_q, release_cnt_q;
    logic        out_valid_q, touch_down_q, overrun_q;
    logic [1:0]  event_type_q;
    logic [9:0]  pix_x_q;
    logic [8:0]  pix_y_q;

    // Signed 13-bit subtract so a raw value below MIN goes negative
    // and clamps to 0 instead of wrapping.
    function automatic logic [10:0] clamp_axis(input logic [11:0] raw,
                                               input logic [11:0] lo,
                                               input logic [10:0] span);
        logic signed [12:0] diff;
        diff = $signed({1'b0, raw}) - $signed({1'b0, lo});
        if (diff < 13'sd0)
            return 11'd0;
        else if (diff > $signed({2'b00, span}))
            return span;
        else
            return diff[10:0];
    endfunction

    // ---------------- FSM ----------------
    always_ff @(posedge cclk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CLAMP;
            CLAMP:   state_d = MUL;
            MUL:     if (cnt_q == 4'd15) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FINISH-stage combinational results ----------------
    logic       pressed;
    logic [2:0] press_cnt_d, release_cnt_d;
    logic [9:0] new_x, move_x;
    logic [8:0] new_y, move_y;

    always_comb begin
        pressed       = (z_q >= Z_THRESH);
        press_cnt_d   = 3'd0;
        release_cnt_d = 3'd0;
        if (pressed)
            press_cnt_d = (press_cnt_q == 3'd7) ? press_cnt_q : press_cnt_q + 3'd1;
        else
            release_cnt_d = (release_cnt_q == 3'd7) ? release_cnt_q : release_cnt_q + 3'd1;

        new_x = (acc_x_q[26:16] > 11'd799) ? 10'd799 : acc_x_q[25:16];
        new_y = (acc_y_q[26:16] > 11'd479) ? 9'd479  : acc_y_q[24:16];

`ifdef TOUCH_FILTER_EN
        // The reported position doubles as the filter history.
        move_x = 10'(({1'b0, pix_x_q} + {1'b0, new_x} + 11'd1) >> 1);
        move_y = 9'(({1'b0, pix_y_q} + {1'b0, new_y} + 10'd1) >> 1);
`else
        move_x = new_x;
        move_y = new_y;
`endif
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge cclk) begin
        if (rst) begin
            cnt_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            z_q           <= '0;
            mcand_x_q     <= '0;
            mcand_y_q     <= '0;
            acc_x_q       <= '0;
            acc_y_q       <= '0;
            mplier_x_q    <= '0;
            mplier_y_q    <= '0;
            press_cnt_q   <= '0;
            release_cnt_q <= '0;
            out_valid_q   <= 1'b0;
            event_type_q  <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            touch_down_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (in_valid && state_q != IDLE)
                overrun_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q <= x;
                        y_q <= y;
                        z_q <= z;
                    end
                end
                CLAMP: begin
                    mcand_x_q  <= {16'd0, clamp_axis(x_q, X_MIN, X_SPAN[10:0])};
                    mcand_y_q  <= {16'd0, clamp_axis(y_q, Y_MIN, Y_SPAN[10:0])};
                    mplier_x_q <= K_X;
                    mplier_y_q <= K_Y;
                    acc_x_q    <= '0;
                    acc_y_q    <= '0;
                    cnt_q      <= '0;
                end
                MUL: begin
                    // One multiplier bit per cycle, LSB first.
                    if (mplier_x_q[0]) acc_x_q <= acc_x_q + mcand_x_q;
                    if (mplier_y_q[0]) acc_y_q <= acc_y_q + mcand_y_q;
                    mcand_x_q  <= mcand_x_q << 1;
                    mcand_y_q  <= mcand_y_q << 1;
                    mplier_x_q <= mplier_x_q >> 1;
                    mplier_y_q <= mplier_y_q >> 1;
                    cnt_q      <= cnt_q + 4'd1;
                end
                FINISH: begin
                    press_cnt_q   <= press_cnt_d;
                    release_cnt_q <= release_cnt_d;
                    if (!touch_down_q && press_cnt_d >= PRESS_CNT3) begin
                        touch_down_q <= 1'b1;
                        pix_x_q      <= new_x;
                        pix_y_q      <= new_y;
                        event_type_q <= EV_PRESS;
                        out_valid_q  <= 1'b1;
                    end else if (touch_down_q && pressed) begin
                        pix_x_q      <= move_x;
                        pix_y_q      <= move_y;
                        event_type_q <= EV_MOVE;
                        out_valid_q  <= 1'b1;
                    end else if (touch_down_q && release_cnt_d >= RELEASE_CNT3) begin
                        touch_down_q <= 1'b0;
                        event_type_q <= EV_RELEASE;
                        out_valid_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign out_valid  = out_valid_q;
    assign event_type = event_type_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign touch_down = touch_down_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_touch_coord_mapper.sv
module tb_touch_coord_mapper;

    logic        cclk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [11:0] x, y, z;
    logic        busy, out_valid, touch_down, overrun;
    logic [1:0]  event_type;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;

    int checks = 0;
    int passed = 0;
    logic exp_ovr = 1'b0;

    always #5 cclk = ~cclk;

    touch_coord_mapper dut (
        .cclk      (cclk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .z         (z),
        .busy      (busy),
        .out_valid (out_valid),
        .event_type(event_type),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .touch_down(touch_down),
        .overrun   (overrun)
    );

    typedef struct {
        logic [11:0] x, y, z;
        logic        ev;
        logic [1:0]  et;
        int          px, py;
        logic        td;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp)
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        else
            passed++;
    endtask

    // Final-edge checks, shared by the table and hand sequences.
    task automatic chk_result(input string tag, input logic early, input logic ev,
                              input logic [1:0] et, input int px, input int py,
                              input logic td);
        chk({tag, " no_early_valid"}, int'(early), 0);
        chk({tag, " out_valid"},  int'(out_valid), int'(ev));
        chk({tag, " event_type"}, int'(event_type), int'(et));
        chk({tag, " pix_x"},      int'(pix_x), px);
        chk({tag, " pix_y"},      int'(pix_y), py);
        chk({tag, " touch_down"}, int'(touch_down), int'(td));
        chk({tag, " overrun"},    int'(overrun), int'(exp_ovr));
        $display("%s: out_valid=%0b type=%b pix=(%0d,%0d) down=%0b overrun=%0b",
                 tag, out_valid, event_type, pix_x, pix_y, touch_down, overrun);
    endtask

    // Entered #1 after a posedge; returns #1 after the edge ending FINISH,
    // so back-to-back calls exercise the 19-cycle throughput.
    task automatic run_sample(input string tag, input logic [11:0] sx,
                              input logic [11:0] sy, input logic [11:0] sz,
                              input logic ev, input logic [1:0] et,
                              input int px, input int py, input logic td);
        logic early;
        in_valid = 1'b1; x = sx; y = sy; z = sz;
        @(posedge cclk); #1;
        in_valid = 1'b0;
        chk({tag, " busy"}, int'(busy), 1);
        early = 1'b0;
        for (int i = 1; i < 18; i++) begin
            @(posedge cclk); #1;
            if (out_valid) early = 1'b1;
        end
        @(posedge cclk); #1;
        chk_result(tag, early, ev, et, px, py, td);
    endtask

    initial begin
        logic early;

        // Filter-off expectations, with filtered values where MOVE differs.
        vecs[0] = '{12'h090, 12'h060, 12'h200, 1'b0, 2'b00,   0,   0, 1'b0};
        vecs[1] = '{12'h090, 12'h060, 12'h200, 1'b0, 2'b00,   0,   0, 1'b0};
        vecs[2] = '{12'h090, 12'h060, 12'h200, 1'b1, 2'b01,   0,   0, 1'b1};
`ifdef TOUCH_FILTER_EN
        vecs[3] = '{12'h7D5, 12'h750, 12'h200, 1'b1, 2'b10, 400, 240, 1'b1};
        vecs[4] = '{12'hFFF, 12'h750, 12'h200, 1'b1, 2'b10, 600, 360, 1'b1};
        vecs[5] = '{12'h000, 12'h060, 12'h200, 1'b1, 2'b10, 300, 180, 1'b1};
        vecs[6] = '{12'h200, 12'h200, 12'h07F, 1'b0, 2'b10, 300, 180, 1'b1};
        vecs[7] = '{12'h432, 12'h060, 12'h080, 1'b1, 2'b10, 350,  90, 1'b1};
        vecs[8] = '{12'h100, 12'h100, 12'h010, 1'b0, 2'b10, 350,  90, 1'b1};
        vecs[9] = '{12'h100, 12'h100, 12'h010, 1'b1, 2'b11, 350,  90, 1'b0};
`else
        vecs[3] = '{12'h7D5, 12'h750, 12'h200, 1'b1, 2'b10, 799, 479, 1'b1};
        vecs[4] = '{12'hFFF, 12'h750, 12'h200, 1'b1, 2'b10, 799, 479, 1'b1};
        vecs[5] = '{12'h000, 12'h060, 12'h200, 1'b1, 2'b10,   0,   0, 1'b1};
        vecs[6] = '{12'h200, 12'h200, 12'h07F, 1'b0, 2'b10,   0,   0, 1'b1};
        vecs[7] = '{12'h432, 12'h060, 12'h080, 1'b1, 2'b10, 399,   0, 1'b1};
        vecs[8] = '{12'h100, 12'h100, 12'h010, 1'b0, 2'b10, 399,   0, 1'b1};
        vecs[9] = '{12'h100, 12'h100, 12'h010, 1'b1, 2'b11, 399,   0, 1'b0};
`endif

        // Reset state
        rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; z = '0;
        repeat (3) @(posedge cclk);
        #1;
        chk("reset busy",       int'(busy), 0);
        chk("reset out_valid",  int'(out_valid), 0);
        chk("reset event_type", int'(event_type), 0);
        chk("reset pix_x",      int'(pix_x), 0);
        chk("reset pix_y",      int'(pix_y), 0);
        chk("reset touch_down", int'(touch_down), 0);
        chk("reset overrun",    int'(overrun), 0);
        rst = 1'b0;

        // First sample is offered on the first cycle after reset deasserts.
        for (int i = 0; i < 10; i++)
            run_sample($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].z,
                       vecs[i].ev, vecs[i].et, vecs[i].px, vecs[i].py, vecs[i].td);

        // Overrun: two pressed samples, then a third with a second strobe
        // 5 cycles later carrying an unpressed sample that must be dropped.
`ifdef TOUCH_FILTER_EN
        run_sample("ovr_a", 12'h090, 12'h060, 12'h200, 1'b0, 2'b11, 350, 90, 1'b0);
        run_sample("ovr_b", 12'h090, 12'h060, 12'h200, 1'b0, 2'b11, 350, 90, 1'b0);
`else
        run_sample("ovr_a", 12'h090, 12'h060, 12'h200, 1'b0, 2'b11, 399, 0, 1'b0);
        run_sample("ovr_b", 12'h090, 12'h060, 12'h200, 1'b0, 2'b11, 399, 0, 1'b0);
`endif
        in_valid = 1'b1; x = 12'h7D5; y = 12'h750; z = 12'h200;
        @(posedge cclk); #1;
        in_valid = 1'b0;
        early = 1'b0;
        for (int i = 1; i < 18; i++) begin
            @(posedge cclk); #1;
            if (out_valid) early = 1'b1;
            if (i == 4) begin
                in_valid = 1'b1; x = 12'h000; y = 12'h060; z = 12'h010;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge cclk); #1;
        exp_ovr = 1'b1;
        chk_result("ovr_c", early, 1'b1, 2'b01, 799, 479, 1'b1);
        // The dropped sample must not have started its own pass.
`ifdef TOUCH_FILTER_EN
        run_sample("ovr_d", 12'h090, 12'h060, 12'h200, 1'b1, 2'b10, 400, 240, 1'b1);
`else
        run_sample("ovr_d", 12'h090, 12'h060, 12'h200, 1'b1, 2'b10, 0, 0, 1'b1);
`endif

        // Reset during MUL aborts the sample and clears everything.
        in_valid = 1'b1; x = 12'h7D5; y = 12'h750; z = 12'h200;
        @(posedge cclk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge cclk);
        #1;
        rst = 1'b1;
        @(posedge cclk); #1;
        rst = 1'b0;
        exp_ovr = 1'b0;
        chk("midrst busy",       int'(busy), 0);
        chk("midrst out_valid",  int'(out_valid), 0);
        chk("midrst event_type", int'(event_type), 0);
        chk("midrst pix_x",      int'(pix_x), 0);
        chk("midrst pix_y",      int'(pix_y), 0);
        chk("midrst touch_down", int'(touch_down), 0);
        chk("midrst overrun",    int'(overrun), 0);
        $display("midrst: outputs busy=%0b valid=%0b down=%0b overrun=%0b",
                 busy, out_valid, touch_down, overrun);

        // Fresh 3-sample press; the first window would catch a stray event
        // from the aborted sample.
        run_sample("post_a", 12'h432, 12'h060, 12'h200, 1'b0, 2'b00,   0, 0, 1'b0);
        run_sample("post_b", 12'h432, 12'h060, 12'h200, 1'b0, 2'b00,   0, 0, 1'b0);
        run_sample("post_c", 12'h432, 12'h060, 12'h200, 1'b1, 2'b01, 399, 0, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
